// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants and sample types for the I2S transmitter
package i2s_pkg;

  localparam int MCLK_PER_FRAME = 256;
  localparam int MCLK_PER_BCLK  = 4;
  localparam int SLOT_BITS      = 32;
  localparam int SAMPLE_BITS    = 16;
  localparam int GAIN_UNITY     = 256;

  typedef struct packed {
    shortint l;
    shortint r;
  } stereo_sample_t;

endpackage

// File: rtl/soft_mute_ramp.sv
// rtl/soft_mute_ramp.sv - per-frame gain ramp and sample scaling for soft mute
// Gain steps toward 0 while muted and toward unity otherwise, once per step_i.
module soft_mute_ramp
  import i2s_pkg::*;
(
  input  logic           mclk_i,
  input  logic           rst_i,
  input  logic           step_i,
  input  logic           mute_i,
  input  stereo_sample_t sample_i,
  output stereo_sample_t sample_o
);

  localparam logic [8:0] GAIN_MAX = 9'(GAIN_UNITY);

  logic [8:0] gain_q, gain_d;

  always_comb begin
    gain_d = gain_q;
    if (step_i) begin
      if (mute_i) begin
        if (gain_q != 9'd0) gain_d = gain_q - 9'd1;
      end else if (gain_q != GAIN_MAX) begin
        gain_d = gain_q + 9'd1;
      end
    end
  end

  always_ff @(posedge mclk_i or posedge rst_i) begin
    if (rst_i) gain_q <= GAIN_MAX;
    else       gain_q <= gain_d;
  end

  // Pre-step gain is applied; floor shift keeps 256 exact unity and 0 exact zero.
  function automatic shortint scale(input shortint s, input logic [8:0] g);
    logic signed [25:0] p;
    p = $signed(s) * $signed({1'b0, g});
    return shortint'(p[23:8]);
  endfunction

  assign sample_o.l = scale(sample_i.l, gain_q);
  assign sample_o.r = scale(sample_i.r, gain_q);

endmodule

// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - stereo I2S transmitter, bclk/pblrc derived from mclk = 256 fs
// Hard mute by default; I2S_TX_SOFT_MUTE_EN selects the ramped soft mute.
module i2s_tx_serializer #(
  parameter int SAMPLE_BITS       = 16,
  parameter int UNDERRUN_CNT_BITS = 16
) (
  input  logic                         mclk,
  input  logic                         rst,
  input  logic [SAMPLE_BITS-1:0]       sample_l,
  input  logic [SAMPLE_BITS-1:0]       sample_r,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic                         mute,
  output logic                         bclk,
  output logic                         pblrc,
  output logic                         pbdat,
  output logic [UNDERRUN_CNT_BITS-1:0] underrun_count
);

  import i2s_pkg::*;

  if (SAMPLE_BITS != i2s_pkg::SAMPLE_BITS) begin : g_bad_width
    $error("i2s_tx_serializer: SAMPLE_BITS must be 16");
  end

  localparam logic [7:0] CNT_LAST    = 8'(MCLK_PER_FRAME - 1);
  localparam int         BIT_PHASE_W = $clog2(MCLK_PER_BCLK);
  localparam int         SLOT_IDX_W  = $clog2(SLOT_BITS);

  logic [7:0]                   cnt_q, cnt_d;
  stereo_sample_t               hold_q, hold_d;
  logic [UNDERRUN_CNT_BITS-1:0] underrun_q, underrun_d;
  logic                         bclk_q, pblrc_q, pbdat_q, pbdat_d;
  logic                         latch;
  logic [SLOT_IDX_W-1:0]        slot_k;
  logic [15:0]                  word;
  logic                         bit_d;

  assign cnt_d        = cnt_q + 8'd1;
  assign latch        = (cnt_q == CNT_LAST);
  assign sample_ready = latch;

`ifdef I2S_TX_SOFT_MUTE_EN
  stereo_sample_t in_pair, scaled;

  assign in_pair.l = sample_l;
  assign in_pair.r = sample_r;

  soft_mute_ramp u_ramp (
    .mclk_i   (mclk),
    .rst_i    (rst),
    .step_i   (latch),
    .mute_i   (mute),
    .sample_i (in_pair),
    .sample_o (scaled)
  );

  always_comb begin
    hold_d = hold_q;
    if (latch && sample_valid) hold_d = scaled;
  end
`else
  always_comb begin
    hold_d = hold_q;
    if (latch) begin
      if (mute) begin
        hold_d = '0;
      end else if (sample_valid) begin
        hold_d.l = sample_l;
        hold_d.r = sample_r;
      end
    end
  end
`endif

  always_comb begin
    underrun_d = underrun_q;
    if (latch && !sample_valid && underrun_q != '1) underrun_d = underrun_q + 1'b1;
  end

  // Bit index is taken from the next count so all three pins move on one edge.
  // hold_q is safe here: it only changes on the edge that starts k = 0.
  assign slot_k = cnt_d[BIT_PHASE_W +: SLOT_IDX_W];
  assign word   = cnt_d[7] ? hold_q.r : hold_q.l;

  always_comb begin
    bit_d = 1'b0;
    if (slot_k >= 5'd1 && slot_k <= 5'd16) bit_d = word[4'(5'd16 - slot_k)];
  end

  assign pbdat_d = (cnt_d[BIT_PHASE_W-1:0] == '0) ? bit_d : pbdat_q;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      hold_q     <= '0;
      underrun_q <= '0;
      bclk_q     <= 1'b0;
      pblrc_q    <= 1'b0;
      pbdat_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      underrun_q <= underrun_d;
      bclk_q     <= cnt_d[1];
      pblrc_q    <= cnt_d[7];
      pbdat_q    <= pbdat_d;
    end
  end

  assign bclk           = bclk_q;
  assign pblrc          = pblrc_q;
  assign pbdat          = pbdat_q;
  assign underrun_count = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb/tb_i2s_tx_serializer.sv - frame-level bench for i2s_tx_serializer (honours I2S_TX_SOFT_MUTE_EN)
module tb_i2s_tx_serializer;

  logic        mclk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample_l = '0, sample_r = '0;
  logic        sample_valid = 1'b0, mute = 1'b0;
  logic        sample_ready, bclk, pblrc, pbdat;
  logic [15:0] underrun_count;
  logic        sm_ready, sm_bclk, sm_pblrc, sm_pbdat;
  logic [1:0]  sm_under;

  always #5 mclk = ~mclk;

  i2s_tx_serializer #(.SAMPLE_BITS(16), .UNDERRUN_CNT_BITS(16)) dut (
    .mclk(mclk), .rst(rst), .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .mute(mute),
    .bclk(bclk), .pblrc(pblrc), .pbdat(pbdat), .underrun_count(underrun_count)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  i2s_tx_serializer #(.SAMPLE_BITS(16), .UNDERRUN_CNT_BITS(2)) dut_sm (
    .mclk(mclk), .rst(rst), .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .sample_ready(sm_ready), .mute(mute),
    .bclk(sm_bclk), .pblrc(sm_pblrc), .pbdat(sm_pbdat), .underrun_count(sm_under)
  );

  int n_vec = 0, n_bad = 0;

  // Reference model: frame position, held pair, underrun total, gain.
  int          c;
  logic [15:0] m_l, m_r;
  int          m_under, m_gain;
  logic [15:0] obs_l, obs_r;

  typedef struct {
    logic        valid;
    logic [15:0] l, r;
    logic [15:0] exp_l, exp_r;
    int          exp_under;
  } vec_t;
  vec_t tab [8];

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s c=%0d actual=%h required=%h", name, c, act, exp);
    end
  endtask

  task automatic model_reset();
    c = 0; m_l = '0; m_r = '0; m_under = 0; m_gain = 256;
  endtask

  function automatic logic [15:0] scale(input logic [15:0] s, input int g);
    int p;
    p = int'($signed(s)) * g;
    return 16'(p >>> 8);
  endfunction

  task automatic latch_model();
`ifdef I2S_TX_SOFT_MUTE_EN
    if (sample_valid) begin
      m_l = scale(sample_l, m_gain);
      m_r = scale(sample_r, m_gain);
    end
    if (mute) m_gain = (m_gain > 0) ? m_gain - 1 : 0;
    else      m_gain = (m_gain < 256) ? m_gain + 1 : 256;
`else
    if (mute) begin
      m_l = '0; m_r = '0;
    end else if (sample_valid) begin
      m_l = sample_l; m_r = sample_r;
    end
`endif
    if (!sample_valid) m_under++;
  endtask

  function automatic logic exp_bit(input int pos, input logic [15:0] l, input logic [15:0] r);
    int k;
    logic [15:0] w;
    k = (pos % 128) / 4;
    w = (pos < 128) ? l : r;
    if (k >= 1 && k <= 16) return w[16-k];
    return 1'b0;
  endfunction

  task automatic check_cycle();
    logic eb, ep, ed, er;
    int u16, u2;
    eb  = ((c / 2) % 2) == 1;
    ep  = (c >= 128);
    ed  = exp_bit(c, m_l, m_r);
    er  = (c == 255);
    u16 = (m_under > 65535) ? 65535 : m_under;
    u2  = (m_under > 3) ? 3 : m_under;
    compare("pins", {12'd0, bclk, pblrc, pbdat, sample_ready, underrun_count},
            {12'd0, eb, ep, ed, er, 16'(u16)});
    compare("pins_sat2", {26'd0, sm_bclk, sm_pblrc, sm_pbdat, sm_ready, sm_under},
            {26'd0, eb, ep, ed, er, 2'(u2)});
  endtask

  task automatic tick();
    int k;
    @(posedge mclk);
    if (c == 255) latch_model();
    c = (c + 1) % 256;
    @(negedge mclk);
    check_cycle();
    if (c % 4 == 2) begin
      k = (c % 128) / 4;
      if (k >= 1 && k <= 16) begin
        if (c < 128) obs_l[16-k] = pbdat;
        else         obs_r[16-k] = pbdat;
      end
    end
  endtask

  // Called at c == 0; inputs are held for the latch that ends this frame.
  task automatic run_frame(input logic v, input logic [15:0] l, input logic [15:0] r, input logic m);
    sample_valid = v; sample_l = l; sample_r = r; mute = m;
    obs_l = '0; obs_r = '0;
    repeat (256) tick();
  endtask

  initial begin
    tab[0] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1};
    tab[1] = '{1'b1, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE, 1};
    tab[2] = '{1'b1, 16'h1234, 16'h5678, 16'h1234, 16'h5678, 1};
    tab[3] = '{1'b0, 16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678, 2};
    tab[4] = '{1'b0, 16'hAAAA, 16'h5555, 16'h1234, 16'h5678, 3};
    tab[5] = '{1'b0, 16'h0F0F, 16'hF0F0, 16'h1234, 16'h5678, 4};
    tab[6] = '{1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 4};
    tab[7] = '{1'b1, 16'h0001, 16'h8000, 16'h0001, 16'h8000, 4};

    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge mclk);
    check_cycle();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_frame(tab[i].valid, tab[i].l, tab[i].r, 1'b0);
      compare("table_underrun", {16'd0, underrun_count}, tab[i].exp_under);
      if (i == 0) compare("first_frame_words", {obs_l, obs_r}, 32'd0);
      else        compare("table_words", {obs_l, obs_r}, {tab[i-1].exp_l, tab[i-1].exp_r});
    end
    run_frame(1'b0, 16'h0000, 16'h0000, 1'b0);
    compare("table_words", {obs_l, obs_r}, {tab[7].exp_l, tab[7].exp_r});

    for (int i = 0; i < 12; i++)
      run_frame($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 1'b0);

    for (int i = 0; i < 4; i++) run_frame(1'b1, 16'h7FFF, 16'h8000, 1'b1);
    for (int i = 0; i < 3; i++) run_frame(1'b1, 16'h7FFF, 16'h8000, 1'b0);

    repeat (70) tick();
    rst = 1'b1;
    #1;
    compare("async_reset", {12'd0, bclk, pblrc, pbdat, sample_ready, underrun_count}, 32'd0);
    compare("async_reset_sat2", {26'd0, sm_bclk, sm_pblrc, sm_pbdat, sm_ready, sm_under}, 32'd0);
    @(negedge mclk);
    rst = 1'b0;
    model_reset();
    check_cycle();

    run_frame(1'b0, 16'h4321, 16'h8765, 1'b0);
    compare("post_reset_first_words", {obs_l, obs_r}, 32'd0);
    compare("post_reset_underrun", {16'd0, underrun_count}, 32'd1);
    run_frame(1'b1, 16'h4321, 16'h8765, 1'b0);
    run_frame(1'b0, 16'h0000, 16'h0000, 1'b0);
    compare("post_reset_words", {obs_l, obs_r}, 32'h4321_8765);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
